// File: rtl/uart_tx_fifo_pkg.sv
// ============================================================================
// Module : uart_pkg
// Brief  : Shared constants and FSM state type for the UART transmit FIFO.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_pkg;

   localparam int c_DATA_W = 8;
   localparam int c_DEPTH  = 16;
   localparam int c_PTR_W  = $clog2(c_DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      START = 2'b01,
      BUSY  = 2'b10
   } tx_fifo_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_tx_fifo_if.sv
// ============================================================================
// Module : uart_tx_fifo_if
// Brief  : Host write port plus transmitter handshake of the UART TX FIFO.
//          almost_full exists only when UART_TX_FIFO_AF_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface uart_tx_fifo_if #(
   parameter int DATA_W = uart_pkg::c_DATA_W,
   parameter int DEPTH  = uart_pkg::c_DEPTH
);
   localparam int c_CNT_W = $clog2(DEPTH) + 1;

   logic                wr_en;
   logic [DATA_W-1:0]   wr_data;
   logic                full;
   logic                empty;
   logic [c_CNT_W-1:0]  count;
   logic                overflow;
   logic [DATA_W-1:0]   tx_data;
   logic                tx_start;
   logic                tx_done_tick;
`ifdef UART_TX_FIFO_AF_EN
   logic                almost_full;

   modport master (
      output wr_en, wr_data, tx_done_tick,
      input  full, empty, count, overflow, tx_data, tx_start, almost_full
   );
   modport slave (
      input  wr_en, wr_data, tx_done_tick,
      output full, empty, count, overflow, tx_data, tx_start, almost_full
   );
`else
   modport master (
      output wr_en, wr_data, tx_done_tick,
      input  full, empty, count, overflow, tx_data, tx_start
   );
   modport slave (
      input  wr_en, wr_data, tx_done_tick,
      output full, empty, count, overflow, tx_data, tx_start
   );
`endif

endinterface

`default_nettype wire

// File: rtl/uart_tx_fifo_mem.sv
// ============================================================================
// Module : uart_fifo_mem
// Brief  : DEPTH x DATA_W register file, synchronous write, asynchronous read.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_fifo_mem
   import uart_pkg::*;
#(
   parameter int DATA_W = c_DATA_W,
   parameter int DEPTH  = c_DEPTH,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              i_wr_en,
   input  logic [AW-1:0]     i_wr_addr,
   input  logic [DATA_W-1:0] i_wr_data,
   input  logic [AW-1:0]     i_rd_addr,
   output logic [DATA_W-1:0] o_rd_data
);

   logic [DATA_W-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   assign o_rd_data = r_mem[i_rd_addr];

endmodule

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// ============================================================================
// Module : uart_tx_fifo
// Brief  : Byte FIFO feeding a UART transmitter one frame at a time.
//          Define UART_TX_FIFO_AF_EN to add the almost_full flag.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int DATA_W   = c_DATA_W,
   parameter int DEPTH    = c_DEPTH,
   parameter int AF_LEVEL = 12
) (
   input  logic           clk,
   input  logic           reset,
   uart_tx_fifo_if.slave  bus
);

   localparam int              c_AW       = $clog2(DEPTH);
   localparam int              c_CW       = c_AW + 1;
   localparam logic [c_CW-1:0] c_FULL_CNT = c_CW'(DEPTH);

   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("uart_tx_fifo: DEPTH must be a power of two >= 2");
   end
   if ((AF_LEVEL < 1) || (AF_LEVEL > DEPTH)) begin : g_bad_af_level
      $error("uart_tx_fifo: AF_LEVEL must lie in 1..DEPTH");
   end

   logic [c_AW-1:0]   r_wr_ptr;
   logic [c_AW-1:0]   r_rd_ptr;
   logic [c_CW-1:0]   r_count;
   logic              r_full;
   logic              r_empty;
   tx_fifo_state_t    r_state;
   logic [DATA_W-1:0] r_tx_data;
   logic              r_tx_start;
   logic [DATA_W-1:0] w_rd_data;
   logic              w_push;
   logic              w_pop;
   logic [c_CW-1:0]   w_count_nxt;

   // full is the registered flag, so a write while full is dropped even if a pop lands the same cycle
   assign w_push = bus.wr_en & ~r_full;
   assign w_pop  = (r_state == IDLE) & ~r_empty;

   always_comb begin
      w_count_nxt = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + c_CW'(1);
         2'b01:   w_count_nxt = r_count - c_CW'(1);
         default: w_count_nxt = r_count;
      endcase
   end

   uart_fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (c_AW)
   ) u_mem (
      .clk       (clk),
      .i_wr_en   (w_push),
      .i_wr_addr (r_wr_ptr),
      .i_wr_data (bus.wr_data),
      .i_rd_addr (r_rd_ptr),
      .o_rd_data (w_rd_data)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_AW'(1);
         end
         r_count <= w_count_nxt;
         r_full  <= (w_count_nxt == c_FULL_CNT);
         r_empty <= (w_count_nxt == '0);
      end
   end

   // The byte is popped at load, so a slot frees while its frame is still on the wire
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= IDLE;
         r_tx_data  <= '0;
         r_tx_start <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_tx_start <= 1'b0;
               if (w_pop) begin
                  r_tx_data <= w_rd_data;
                  r_state   <= START;
               end
            end
            START: begin
               r_tx_start <= 1'b1;
               r_state    <= BUSY;
            end
            BUSY: begin
               r_tx_start <= 1'b0;
               if (bus.tx_done_tick) begin
                  r_state <= IDLE;
               end
            end
            default: begin
               r_tx_start <= 1'b0;
               r_state    <= IDLE;
            end
         endcase
      end
   end

   assign bus.full     = r_full;
   assign bus.empty    = r_empty;
   assign bus.count    = r_count;
   assign bus.overflow = bus.wr_en & r_full;
   assign bus.tx_data  = r_tx_data;
   assign bus.tx_start = r_tx_start;

`ifdef UART_TX_FIFO_AF_EN
   logic r_almost_full;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_almost_full <= 1'b0;
      end else begin
         r_almost_full <= (w_count_nxt >= c_CW'(AF_LEVEL));
      end
   end

   assign bus.almost_full = r_almost_full;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
// ============================================================================
// Module : tb_uart_tx_fifo
// Brief  : Self-checking bench for uart_tx_fifo with a frame-level reference.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_fifo;
   import uart_pkg::*;

   localparam int DW       = 8;
   localparam int DEPTH    = 16;
   localparam int AF_LEVEL = 12;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   uart_tx_fifo_if #(.DATA_W(DW), .DEPTH(DEPTH)) bus ();

   uart_tx_fifo #(
      .DATA_W   (DW),
      .DEPTH    (DEPTH),
      .AF_LEVEL (AF_LEVEL)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_chk  = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
   endtask

   // Reference: bytes waiting, link availability and the edge at which each start pulse is due
   logic [DW-1:0] mq[$];
   logic [DW-1:0] exp_q[$];
   bit            link_idle  = 1'b1;
   int            edge_no    = 0;
   int            ack_from   = 0;
   int            start_edge = -1;
   logic [DW-1:0] last_tx    = '0;
   int            sz_pre;
   logic [DW-1:0] popped;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         mq.delete();
         exp_q.delete();
         link_idle  = 1'b1;
         start_edge = -1;
         last_tx    = '0;
      end else begin
         edge_no++;
         sz_pre = mq.size();
         if (link_idle && sz_pre > 0) begin
            popped     = mq.pop_front();
            exp_q.push_back(popped);
            last_tx    = popped;
            link_idle  = 1'b0;
            start_edge = edge_no + 1;
            ack_from   = edge_no + 2;
         end else if (!link_idle && bus.tx_done_tick && edge_no >= ack_from) begin
            link_idle = 1'b1;
         end
         if (bus.wr_en && sz_pre < DEPTH) mq.push_back(bus.wr_data);
      end
   end

   int sz_m;
   always @(negedge clk) begin
      sz_m = mq.size();
      check("count",    32'(bus.count),    32'(sz_m));
      check("empty",    32'(bus.empty),    32'(sz_m == 0));
      check("full",     32'(bus.full),     32'(sz_m == DEPTH));
      check("overflow", 32'(bus.overflow), 32'(bus.wr_en && sz_m == DEPTH));
      check("tx_start", 32'(bus.tx_start), 32'(start_edge == edge_no));
      check("tx_data",  32'(bus.tx_data),  32'(last_tx));
`ifdef UART_TX_FIFO_AF_EN
      check("almost_full", 32'(bus.almost_full), 32'(sz_m >= AF_LEVEL));
`endif
      if (bus.tx_start === 1'b1) begin
         if (exp_q.size() > 0) check("frame_data", 32'(bus.tx_data), 32'(exp_q.pop_front()));
         else                  check("frame_expected", 32'(exp_q.size()), 32'd1);
      end
   end

   // Transmitter emulation plus host writes, one clock per call
   int tx_left  = 0;
   int tx_delay = 4;
   bit tx_hold  = 1'b0;

   task automatic step(input bit wr, input logic [DW-1:0] d, input bit spur);
      bus.wr_en        = wr;
      bus.wr_data      = d;
      bus.tx_done_tick = spur;
      if (bus.tx_start === 1'b1) begin
         tx_left = tx_delay;
      end else if (tx_left > 0 && !tx_hold) begin
         tx_left--;
         if (tx_left == 0) bus.tx_done_tick = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      for (int i = 0; i < 6000; i++) begin
         if (mq.size() == 0 && link_idle) break;
         step(1'b0, '0, 1'b0);
      end
      step(1'b0, '0, 1'b0);
      check("drained_empty", 32'(bus.empty), 32'd1);
   endtask

   int wr_pct;

   initial begin
      bus.wr_en        = 1'b0;
      bus.wr_data      = '0;
      bus.tx_done_tick = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;

      // Single byte
      tx_delay = 6;
      step(1'b1, 8'hA5, 1'b0);
      repeat (15) step(1'b0, '0, 1'b0);

      // Burst past full with the transmitter stalled
      tx_hold = 1'b1;
      for (int i = 1; i <= 20; i++) step(1'b1, DW'(i), 1'b0);
      repeat (3) step(1'b0, '0, 1'b0);
      tx_hold = 1'b0;
      drain();

      // Long frames
      tx_delay = 200;
      step(1'b1, 8'h11, 1'b0);
      step(1'b1, 8'h22, 1'b0);
      step(1'b1, 8'h33, 1'b0);
      drain();

      // Stray done ticks while idle and during START
      tx_delay = 4;
      repeat (3) step(1'b0, '0, 1'b1);
      step(1'b1, 8'h5A, 1'b0);
      step(1'b0, '0, 1'b0);
      step(1'b0, '0, 1'b1);
      drain();

      // Random traffic at several write densities
      for (int i = 0; i < 1800; i++) begin
         wr_pct   = (i < 600) ? 20 : ((i < 1200) ? 60 : 95);
         tx_delay = int'($urandom_range(1, 12));
         step(($urandom_range(0, 99) < wr_pct), DW'($urandom), ($urandom_range(0, 99) < 3));
      end
      drain();

      // Reset in the middle of a frame with bytes still queued
      tx_hold = 1'b1;
      for (int i = 0; i < 5; i++) step(1'b1, DW'(8'hC0 + i), 1'b0);
      repeat (3) step(1'b0, '0, 1'b0);
      #2;
      reset = 1'b0;
      #1;
      check("rst_empty",    32'(bus.empty),    32'd1);
      check("rst_count",    32'(bus.count),    32'd0);
      check("rst_tx_data",  32'(bus.tx_data),  32'd0);
      check("rst_tx_start", 32'(bus.tx_start), 32'd0);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      reset   = 1'b1;
      tx_hold = 1'b0;
      tx_left = 0;
      repeat (20) step(1'b0, '0, 1'b0);
      check("final_count", 32'(bus.count), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
